// File: rtl/mdio_arbiter_pkg.sv
// Shared types and frame constants for the MDIO arbiter slice.
package mdio_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_WAIT  = 5'b00100,
    S_RESP  = 5'b01000,
    S_TURN  = 5'b10000
  } state_t;

  localparam logic [1:0]  MDIO_ST    = 2'b01;
  localparam logic [1:0]  MDIO_OP_RD = 2'b10;
  localparam logic [1:0]  MDIO_OP_WR = 2'b01;
  localparam logic [15:0] ERR_DATA   = 16'hFFFF;

  function automatic logic frame_ok(input logic [31:0] frame);
    return frame[31:30] == MDIO_ST;
  endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Requester and MDIO-master bus bundle for the arbiter; slave is the arbiter side.
interface mdio_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_frame;
  logic [NREQ-1:0]      resp_valid;
  logic [15:0]          resp_data;
  logic                 resp_err;
  logic                 busy;
  logic                 mdio_start;
  logic [31:0]          t_data;
  logic                 data_rdy;
  logic [15:0]          rd_data;

  modport slave (
    input  req, req_frame, data_rdy, rd_data,
    output resp_valid, resp_data, resp_err, busy, mdio_start, t_data
  );

  modport master (
    output req, req_frame, data_rdy, rd_data,
    input  resp_valid, resp_data, resp_err, busy, mdio_start, t_data
  );
endinterface

// File: rtl/mdio_arbiter_rr_pick.sv
// Combinational round-robin selector: first request after ptr, wrapping around.
module rr_pick #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  always_comb begin
    logic        found;
    int unsigned pos;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[PTR_W'(pos)]) begin
        found                = 1'b1;
        gnt[PTR_W'(pos)]     = 1'b1;
        gnt_idx              = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Round-robin sequencer sharing one MDIO master between NREQ management clients.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           reset,
  mdio_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [NREQ-1:0]  ONE      = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_n;
  logic [PTR_W-1:0]  ptr_q, ptr_n;
  logic [PTR_W-1:0]  winner_q, winner_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [31:0]       t_data_q, t_data_n;
  logic [15:0]       resp_data_q, resp_data_n;
  logic              resp_err_q, resp_err_n;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_n;
  logic              mdio_start_q, mdio_start_n;
  logic              busy_q, busy_n;

  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [31:0]       frames [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_frames
    assign frames[g] = bus.req_frame[32*g +: 32];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Outputs are registered from the next state, so each strobe lines up with
  // the cycle the FSM actually sits in ISSUE or RESP.
  always_comb begin
    state_n      = state_q;
    ptr_n        = ptr_q;
    winner_n     = winner_q;
    cnt_n        = cnt_q;
    t_data_n     = t_data_q;
    resp_data_n  = resp_data_q;
    resp_err_n   = resp_err_q;
    resp_valid_n = '0;
    mdio_start_n = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          winner_n = gnt_idx;
          ptr_n    = gnt_idx;
          if (frame_ok(frames[gnt_idx])) begin
            t_data_n     = frames[gnt_idx];
            mdio_start_n = 1'b1;
            state_n      = S_ISSUE;
          end else begin
            resp_valid_n = gnt;
            resp_data_n  = ERR_DATA;
            resp_err_n   = 1'b1;
            state_n      = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_rdy) begin
          resp_valid_n = ONE << winner_q;
          resp_data_n  = bus.rd_data;
          resp_err_n   = 1'b0;
          state_n      = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_n = ONE << winner_q;
          resp_data_n  = ERR_DATA;
          resp_err_n   = 1'b1;
          state_n      = S_RESP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_n = S_TURN;
      S_TURN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= PTR_W'(NREQ - 1);
      winner_q     <= '0;
      cnt_q        <= '0;
      t_data_q     <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      mdio_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      ptr_q        <= ptr_n;
      winner_q     <= winner_n;
      cnt_q        <= cnt_n;
      t_data_q     <= t_data_n;
      resp_data_q  <= resp_data_n;
      resp_err_q   <= resp_err_n;
      resp_valid_q <= resp_valid_n;
      mdio_start_q <= mdio_start_n;
      busy_q       <= busy_n;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;
  assign bus.mdio_start = mdio_start_q;
  assign bus.t_data     = t_data_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed and randomized bench for mdio_arbiter with a round-robin reference model.
module tb_mdio_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdio_arbiter_if #(.NREQ(N)) bus ();

  mdio_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] frm [N];
  for (genvar g = 0; g < N; g++) begin : g_frm
    assign bus.req_frame[32*g +: 32] = frm[g];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int starts   = 0;
  int last     = N - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mdio_start === 1'b1) starts++;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    logic [N-1:0] t;
    for (int k = 1; k <= N; k++) begin
      t = r >> ((from + k) % N);
      if (t[0]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_frame(input bit good);
    logic [31:0] f;
    f = $urandom;
    if (good) f[31:30] = 2'b01;
    else      f[31:30] = (f[31:30] == 2'b01) ? 2'b11 : f[31:30];
    return f;
  endfunction

  // delay < 0 means the master never answers; otherwise data_rdy is seen
  // by the DUT after 'delay' idle cycles in WAIT.
  task automatic run_txn(input int delay, input logic [15:0] rd, input bit drop, input string tag);
    int           w;
    logic [31:0]  f;
    logic [15:0]  exp_d;
    logic         exp_e;
    logic [N-1:0] oh;
    bit           early;
    w = pick(bus.req, last);
    if (w < 0) begin
      check({tag, " has_request"}, 32'd0, 32'd1);
      return;
    end
    last = w;
    f = frm[w];
    for (int i = 0; i < N; i++) oh[i] = (i == w);
    starts = 0;
    step();
    check({tag, " busy_after_grant"}, bus.busy, 1);
    if (f[31:30] != 2'b01) begin
      exp_e = 1'b1;
      exp_d = 16'hFFFF;
    end else begin
      check({tag, " t_data"}, bus.t_data, f);
      step();
      if (delay < 0) begin
        early = 0;
        repeat (TO - 1) begin
          step();
          if (bus.resp_valid !== '0) early = 1;
        end
        check({tag, " no_early_resp"}, 32'(early), 0);
        step();
        exp_e = 1'b1;
        exp_d = 16'hFFFF;
      end else begin
        repeat (delay) step();
        bus.data_rdy = 1'b1;
        bus.rd_data  = rd;
        step();
        bus.data_rdy = 1'b0;
        bus.rd_data  = 16'($urandom);
        exp_e = 1'b0;
        exp_d = rd;
      end
    end
    check({tag, " resp_valid"}, bus.resp_valid, oh);
    check({tag, " resp_data"}, bus.resp_data, exp_d);
    check({tag, " resp_err"}, bus.resp_err, exp_e);
    check({tag, " start_count"}, starts, (f[31:30] == 2'b01) ? 1 : 0);
    if (drop) bus.req = bus.req & ~oh;
    step();
    check({tag, " turn_no_resp"}, bus.resp_valid, 0);
    check({tag, " turn_busy"}, bus.busy, 1);
    check({tag, " resp_data_hold"}, bus.resp_data, exp_d);
    step();
    check({tag, " idle_busy"}, bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " resp_valid"}, bus.resp_valid, 0);
    check({tag, " resp_data"}, bus.resp_data, 0);
    check({tag, " resp_err"}, bus.resp_err, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " mdio_start"}, bus.mdio_start, 0);
    check({tag, " t_data"}, bus.t_data, 0);
  endtask

  initial begin
    bus.req      = '0;
    bus.data_rdy = 1'b0;
    bus.rd_data  = '0;
    for (int i = 0; i < N; i++) frm[i] = '0;

    // Reset state
    reset = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    reset = 1'b1;

    // Single read
    frm[1]  = 32'h6020_0000;
    bus.req = 4'b0010;
    run_txn(14, 16'hBEEF, 1, "single");

    // Simultaneous requests right after a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    last  = N - 1;
    for (int i = 0; i < N; i++) frm[i] = rand_frame(1);
    bus.req = 4'b1111;
    for (int k = 0; k < N; k++) run_txn(5, 16'($urandom), 1, "simul");

    // Fairness with two requesters held high
    bus.req = 4'b0101;
    for (int k = 0; k < 6; k++) run_txn(3, 16'($urandom), 0, "fair");
    bus.req = '0;

    // data_rdy and timeout coincide: data wins
    frm[2]  = rand_frame(1);
    bus.req = 4'b0100;
    run_txn(TO - 1, 16'h1357, 1, "boundary");

    // Timeout
    frm[0]  = rand_frame(1);
    bus.req = 4'b0001;
    run_txn(-1, 16'h0000, 1, "timeout");

    // Malformed frame
    frm[3]  = 32'hC000_0000;
    bus.req = 4'b1000;
    run_txn(0, 16'h0000, 1, "malformed");

    // Reset in the middle of WAIT, then a stray data_rdy
    frm[1]  = rand_frame(1);
    bus.req = 4'b0010;
    repeat (5) step();
    reset   = 1'b0;
    bus.req = '0;
    step();
    reset = 1'b1;
    check_all_zero("midreset");
    bus.data_rdy = 1'b1;
    bus.rd_data  = 16'h1234;
    step();
    bus.data_rdy = 1'b0;
    check("stray resp_valid", bus.resp_valid, 0);
    check("stray busy", bus.busy, 0);
    check("stray mdio_start", bus.mdio_start, 0);
    last = N - 1;
    frm[0]  = rand_frame(1);
    frm[3]  = rand_frame(1);
    bus.req = 4'b1011;
    run_txn(2, 16'h4242, 1, "post_reset");
    bus.req = '0;

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 1) == 1) begin
          bus.req[i] = 1'b1;
          frm[i]     = rand_frame($urandom_range(0, 3) != 0);
        end
      end
      if (bus.req == '0) begin
        bus.req[0] = 1'b1;
        frm[0]     = rand_frame(1);
      end
      run_txn(($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
              16'($urandom), $urandom_range(0, 3) != 0, "random");
    end
    bus.req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
